// File: rtl/encoder_4x2_reg_pkg.sv
// Shared constants and types for the registered one-hot to binary encoder.
// Other N-to-log2 encoders import this package and can reuse the same state type.
package encoder_4x2_reg_pkg;

    localparam int N_IN_DEF      = 4;
    localparam int N_OUT_DEF     = $clog2(N_IN_DEF);
    localparam int ERR_CNT_W_DEF = 8;
    localparam int ERR_CNT_MAX   = (1 << ERR_CNT_W_DEF) - 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } outState_e;

endpackage

// File: rtl/encoder_4x2_reg_if.sv
// Handshake bus between the upstream code source and the encoder, including
// the result side that feeds the downstream binary bus.
interface encoder_4x2_reg_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = $clog2(N_IN)
);

    logic [N_IN-1:0]  data_in;
    logic             in_valid;
    logic             in_ready;
    logic [N_OUT-1:0] y_out;
    logic             out_valid;
    logic             out_ready;
    logic             err_out;
    logic             zero_out;

    // The master supplies codes and consumes results.
    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, y_out, out_valid, err_out, zero_out
    );

    // The slave is the encoder itself.
    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, y_out, out_valid, err_out, zero_out
    );

endinterface

// File: rtl/encoder_4x2_reg_prio_enc_comb.sv
// Purely combinational priority encoder: index of the winning set bit plus
// one-hot and all-zero status. An all-zero code yields index 0.
module prio_enc_comb
    import encoder_4x2_reg_pkg::*;
#(
    parameter int N_IN      = N_IN_DEF,
    parameter int N_OUT     = $clog2(N_IN),
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [N_IN-1:0]  code,
    output logic [N_OUT-1:0] index,
    output logic             onehot_ok,
    output logic             all_zero
);

    // Scan in the direction that lets the preferred bit be the last one written.
    always_comb begin
        index = '0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < N_IN; i++) begin
                if (code[i]) begin
                    index = N_OUT'(i);
                end
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (code[i]) begin
                    index = N_OUT'(i);
                end
            end
        end
    end

    // Status flags are independent of the priority direction.
    always_comb begin
        onehot_ok = $onehot(code);
        all_zero  = ~|code;
    end

endmodule

// File: rtl/encoder_4x2_reg.sv
// Registered encoder: takes a one-hot select code through a valid/ready
// handshake, holds its binary index in an output register and counts
// non-one-hot inputs in a saturating counter.
module encoder_4x2_reg
    import encoder_4x2_reg_pkg::*;
#(
    parameter int N_IN      = N_IN_DEF,
    parameter int N_OUT     = $clog2(N_IN),
    parameter int ERR_CNT_W = ERR_CNT_W_DEF,
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt,
    encoder_4x2_reg_if.slave     bus
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    outState_e              state_q;
    outState_e              state_d;
    logic [N_OUT-1:0]       y_q;
    logic [N_OUT-1:0]       y_d;
    logic                   err_q;
    logic                   err_d;
    logic                   zero_q;
    logic                   zero_d;
    logic [ERR_CNT_W-1:0]   cnt_q;
    logic [ERR_CNT_W-1:0]   cnt_d;

    logic [N_OUT-1:0]       encIndex;
    logic                   encOneHot;
    logic                   encZero;
    logic                   outValid;
    logic                   inReady;
    logic                   accept;

    prio_enc_comb #(
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .PRIO_HIGH (PRIO_HIGH)
    ) u_prio_enc (
        .code      (bus.data_in),
        .index     (encIndex),
        .onehot_ok (encOneHot),
        .all_zero  (encZero)
    );

    // Output-register state flop; reset discards any held result at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill on accept; a full register empties only when drained without a refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Handshake decode: room exists when empty or when the held word leaves now.
    always_comb begin
        outValid = (state_q == ST_FULL);
        inReady  = en & (~outValid | bus.out_ready);
        accept   = bus.in_valid & inReady;
    end

    // Result payload loads only on accept, so it is stable under backpressure.
    always_comb begin
        y_d    = y_q;
        err_d  = err_q;
        zero_d = zero_q;
        if (accept) begin
            y_d    = encIndex;
            err_d  = ~encOneHot;
            zero_d = encZero;
        end
    end

    // Payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            err_q  <= err_d;
            zero_q <= zero_d;
        end
    end

    // Error counter: clear wins over a same-cycle increment, and it sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (accept && !encOneHot && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.y_out     = y_q;
    assign bus.err_out   = err_q;
    assign bus.zero_out  = zero_q;
    assign err_cnt       = cnt_q;

endmodule

// File: tb/tb_encoder_4x2_reg.sv
// Bench for encoder_4x2_reg: two instances share one stimulus stream, one with
// default parameters (high priority, 8-bit counter) and one with low priority
// and a 2-bit counter, both compared against a cycle-level reference model.
module tb_encoder_4x2_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clrCnt;
    logic [3:0] dataIn;
    logic       inValid;
    logic       outReady;
    logic [7:0] errCntA;
    logic [1:0] errCntB;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit refValid;
    int refYA;
    int refYB;
    bit refErr;
    bit refZero;
    int refCntA;
    int refCntB;

    encoder_4x2_reg_if #(.N_IN(4), .N_OUT(2)) busA ();
    encoder_4x2_reg_if #(.N_IN(4), .N_OUT(2)) busB ();

    assign busA.data_in   = dataIn;
    assign busA.in_valid  = inValid;
    assign busA.out_ready = outReady;
    assign busB.data_in   = dataIn;
    assign busB.in_valid  = inValid;
    assign busB.out_ready = outReady;

    encoder_4x2_reg dutA (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr_cnt (clrCnt),
        .err_cnt (errCntA),
        .bus     (busA)
    );

    encoder_4x2_reg #(
        .ERR_CNT_W (2),
        .PRIO_HIGH (1'b0)
    ) dutB (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr_cnt (clrCnt),
        .err_cnt (errCntB),
        .bus     (busB)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Highest set bit is floor(log2(code)); lowest set bit is log2 of the isolated LSB.
    function automatic int refIndex(input logic [3:0] code, input bit high);
        logic [3:0] iso;
        logic [4:0] codeP1;
        if (code == 4'd0) return 0;
        if (high) begin
            codeP1 = {1'b0, code} + 5'd1;
            return $clog2(codeP1) - 1;
        end
        iso = code & (~code + 4'd1);
        return $clog2(iso);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkState();
        checkOutput("out_valid_a", 32'(busA.out_valid), 32'(refValid));
        checkOutput("out_valid_b", 32'(busB.out_valid), 32'(refValid));
        checkOutput("err_cnt_a", 32'(errCntA), 32'(refCntA));
        checkOutput("err_cnt_b", 32'(errCntB), 32'(refCntB));
        if (refValid) begin
            checkOutput("y_out_a", 32'(busA.y_out), 32'(refYA));
            checkOutput("y_out_b", 32'(busB.y_out), 32'(refYB));
            checkOutput("err_out_a", 32'(busA.err_out), 32'(refErr));
            checkOutput("err_out_b", 32'(busB.err_out), 32'(refErr));
            checkOutput("zero_out_a", 32'(busA.zero_out), 32'(refZero));
            checkOutput("zero_out_b", 32'(busB.zero_out), 32'(refZero));
        end
    endtask

    // One cycle: drive at the falling edge, check ready, step model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit e, input logic [3:0] d, input bit v, input bit r, input bit c);
        bit expReady;
        bit acc;
        bit isErr;
        en       = e;
        dataIn   = d;
        inValid  = v;
        outReady = r;
        clrCnt   = c;
        #1;
        expReady = e && (!refValid || r);
        checkOutput("in_ready_a", 32'(busA.in_ready), 32'(expReady));
        checkOutput("in_ready_b", 32'(busB.in_ready), 32'(expReady));
        acc   = v && expReady;
        isErr = ($countones(d) != 1);
        @(posedge clk);
        if (acc) begin
            refValid = 1'b1;
            refYA    = refIndex(d, 1'b1);
            refYB    = refIndex(d, 1'b0);
            refErr   = isErr;
            refZero  = (d == 4'd0);
        end else if (r) begin
            refValid = 1'b0;
        end
        if (c) begin
            refCntA = 0;
            refCntB = 0;
        end else if (acc && isErr) begin
            refCntA = (refCntA < 255) ? refCntA + 1 : 255;
            refCntB = (refCntB < 3) ? refCntB + 1 : 3;
        end
        @(negedge clk);
        checkState();
    endtask

    task automatic resetModel();
        refValid = 1'b0;
        refYA    = 0;
        refYB    = 0;
        refErr   = 1'b0;
        refZero  = 1'b0;
        refCntA  = 0;
        refCntB  = 0;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        clrCnt   = 1'b0;
        dataIn   = 4'd0;
        inValid  = 1'b0;
        outReady = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(busA.out_valid), 32'd0);
        checkOutput("rst_y_out", 32'(busA.y_out), 32'd0);
        checkOutput("rst_err_out", 32'(busA.err_out), 32'd0);
        checkOutput("rst_zero_out", 32'(busA.zero_out), 32'd0);
        checkOutput("rst_err_cnt", 32'(errCntA), 32'd0);
        rst = 1'b0;

        // One-hot sweep, back to back, then drain.
        applyStimulus(1, 4'b0001, 1, 1, 0);
        applyStimulus(1, 4'b0010, 1, 1, 0);
        applyStimulus(1, 4'b0100, 1, 1, 0);
        applyStimulus(1, 4'b1000, 1, 1, 0);
        applyStimulus(1, 4'b0000, 0, 1, 0);

        // All-zero then multi-hot.
        applyStimulus(1, 4'b0000, 1, 1, 0);
        applyStimulus(1, 4'b0110, 1, 1, 0);
        applyStimulus(1, 4'b0000, 0, 1, 0);

        // Backpressure: hold a result for three cycles while a new word waits.
        applyStimulus(1, 4'b0100, 1, 1, 0);
        repeat (3) applyStimulus(1, 4'b1000, 1, 0, 0);
        applyStimulus(1, 4'b1000, 1, 1, 0);
        applyStimulus(1, 4'b0000, 0, 1, 0);

        // Enable low: nothing accepted, but the held result still drains.
        applyStimulus(1, 4'b0010, 1, 1, 0);
        repeat (2) applyStimulus(0, 4'b0001, 1, 0, 0);
        applyStimulus(0, 4'b0001, 1, 1, 0);
        applyStimulus(0, 4'b0001, 1, 1, 0);

        // Saturation of the narrow counter, then clear racing an error.
        applyStimulus(1, 4'b0000, 0, 1, 1);
        repeat (5) applyStimulus(1, 4'b1011, 1, 1, 0);
        applyStimulus(1, 4'b0101, 1, 1, 1);
        applyStimulus(1, 4'b0000, 0, 1, 0);

        // Asynchronous reset between edges while a result is held.
        applyStimulus(1, 4'b1100, 1, 1, 0);
        inValid  = 1'b0;
        outReady = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 32'(busA.out_valid), 32'd0);
        checkOutput("async_rst_y_out", 32'(busA.y_out), 32'd0);
        checkOutput("async_rst_err_cnt", 32'(errCntA), 32'd0);
        checkOutput("async_rst_err_cnt_b", 32'(errCntB), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        resetModel();
        applyStimulus(1, 4'b1000, 1, 1, 0);
        applyStimulus(1, 4'b0000, 0, 1, 0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 7) != 0),
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_4x2_reg.md
Name: encoder_4x2_reg

Overview:
- Registered encoder: the inverse of the team's 2x4 decoder. Takes a 4-bit one-hot code and returns its 2-bit index.
- Sits on the return path from decoded select lines back to a binary bus. Accepts one word per cycle through a valid/ready handshake and holds the result in an output register.
- Flags inputs that are not one-hot (all zero or multi-hot). Counts flagged inputs in a saturating error counter.

Parameters:
- N_IN, 4, input code width; must be a power of two and at least 2.
- N_OUT, 2, output index width; equals log2(N_IN).
- ERR_CNT_W, 8, width of the saturating error counter.
- PRIO_HIGH, 1, multi-hot resolution: 1 = highest set bit wins, 0 = lowest set bit wins.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; while low, no input is accepted.
- data_in  in  N_IN  one-hot input code.
- in_valid  in  1  data_in is valid this cycle.
- in_ready  out  1  block accepts data_in this cycle.
- y_out  out  N_OUT  encoded index (registered).
- out_valid  out  1  y_out and err_out hold a result.
- out_ready  in  1  downstream takes the result this cycle.
- err_out  out  1  the held result came from a non-one-hot input.
- zero_out  out  1  the held result came from an all-zero input.
- err_cnt  out  ERR_CNT_W  saturating count of accepted non-one-hot inputs.
- clr_cnt  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (asynchronous, immediate): y_out=0, out_valid=0, err_out=0, zero_out=0, err_cnt=0.
- in_ready = en & (~out_valid | out_ready). Combinational, no dependence on in_valid.
- Accept = in_valid & in_ready. Latency is 1 cycle: on an accept at edge k, the result appears on y_out/out_valid after edge k.
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL with out_ready=1: accept loads new data and stays FULL; no accept goes to EMPTY.
  - FULL with out_ready=0: hold y_out, err_out and zero_out unchanged.
- Back-to-back: with out_ready held high and in_valid held high, one result per cycle with no bubbles.
- Encoding:
  - One-hot input: y_out = index of the set bit, err_out=0, zero_out=0.
  - All-zero input: y_out=0, err_out=1, zero_out=1.
  - Multi-hot input: y_out = index of the highest set bit (PRIO_HIGH=1) or lowest set bit (PRIO_HIGH=0), err_out=1, zero_out=0.
- err_cnt:
  - Increments by 1 on each accept whose err condition is 1.
  - Saturates at 2^ERR_CNT_W-1.
  - clr_cnt=1 forces 0 at the next edge and has priority over a same-cycle increment.
- en low: in_ready=0 and no new accepts. A FULL register still drains on out_ready.
- Reset mid-transfer: the held result is discarded and out_valid drops immediately.
- Handshake rules downstream may rely on: out_valid never drops without out_ready; y_out is stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package:
  - Local constant for the N_OUT derivation (clog2 of N_IN).
  - Constant ERR_CNT_MAX.
  - Enum for the EMPTY/FULL output state.
- Sub-module prio_enc_comb: purely combinational.
  - Inputs: N_IN-bit code and PRIO_HIGH.
  - Outputs: index, onehot_ok, all_zero.
  - Reused by future N-to-log2 encoders.
- The top level holds the handshake, the output register and the counter.

Test Plan:
- Reset then sweep data_in = 0001, 0010, 0100, 1000 with in_valid=1, out_ready=1, en=1 -> y_out = 0, 1, 2, 3 one cycle later; err_out=0 throughout; no bubbles.
- data_in=0000 -> y_out=0, err_out=1, zero_out=1, err_cnt=1. Then data_in=0110 with PRIO_HIGH=1 -> y_out=2, err_out=1, zero_out=0, err_cnt=2.
- Backpressure: accept 0100, hold out_ready=0 for 3 cycles while offering 1000 -> in_ready=0, y_out stays 2. Release out_ready -> 1000 accepted, y_out=3 on the next cycle.
- en=0 with in_valid=1 -> in_ready=0, no accept. A pending result drains when out_ready=1 and out_valid falls.
- ERR_CNT_W=2: feed 5 multi-hot words -> err_cnt reads 1, 2, 3, 3, 3. Then clr_cnt=1 together with a sixth error -> err_cnt=0.
- Assert rst asynchronously between edges while out_valid=1 -> out_valid, y_out and err_cnt go to 0 immediately. After release, the next accept completes normally.
